// File: rtl/arb_pkg.sv
// Shared types and constants for the packet arbiter mux.
// Requester count, FSM encoding and default beat width.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int DW_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

endpackage

// File: rtl/arb_out_reg.sv
// Single-entry output register for the merged stream.
// Holds data/last while the sink stalls; out_rdy allows a new load.
module arb_out_reg
  import arb_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          load,
  input  logic [DW-1:0] d_data,
  input  logic          d_last,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          out_rdy
);

  assign out_rdy = !m_valid | m_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= d_data;
      m_last  <= d_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/arbiter_pkt_mux.sv
// Packet-granular mux in front of an external round-robin arbiter.
// One arbitration cycle per packet; runaway packets cut at MAX_BEATS.
module arbiter_pkt_mux
  import arb_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MAX_BEATS = 64
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [N_REQ-1:0]          s_valid,
  input  logic [N_REQ-1:0]          s_last,
  input  logic [N_REQ-1:0][DW-1:0]  s_data,
  output logic [N_REQ-1:0]          s_ready,
  output logic [N_REQ-1:0]          o_arb_req,
  input  logic [N_REQ-1:0]          i_arb_grant,
  output logic                      m_valid,
  output logic                      m_last,
  output logic [DW-1:0]             m_data,
  input  logic                      m_ready,
  output logic [15:0]               o_pkt_cnt,
  output logic                      o_err
);

  localparam logic [7:0] LAST_IDX = 8'(MAX_BEATS - 1);

  state_e      state, state_nxt;
  logic [1:0]  sel, sel_nxt;
  logic [7:0]  beat_cnt;
  logic [15:0] pkt_cnt;
  logic        err;
  logic        out_rdy;
  logic        load;
  logic        beat_last;
  logic        force_end;
  logic        grant_ok;
  logic        grant_bad;

  always_comb begin
    o_arb_req = '0;
    s_ready   = '0;
    state_nxt = state;
    sel_nxt   = sel;
    load      = 1'b0;
    beat_last = 1'b0;
    force_end = 1'b0;
    grant_ok  = 1'b0;
    grant_bad = 1'b0;
    unique case (state)
      IDLE: begin
        if (aresetn && out_rdy)
          o_arb_req = s_valid;
        grant_ok  = $onehot(i_arb_grant) &&
                    |(i_arb_grant & o_arb_req);
        grant_bad = |i_arb_grant && !grant_ok;
        if (grant_ok) begin
          state_nxt = XFER;
          unique case (1'b1)
            i_arb_grant[0]: sel_nxt = 2'd0;
            i_arb_grant[1]: sel_nxt = 2'd1;
            i_arb_grant[2]: sel_nxt = 2'd2;
            i_arb_grant[3]: sel_nxt = 2'd3;
          endcase
        end
      end
      XFER: begin
        if (aresetn)
          s_ready[sel] = out_rdy;
        load      = s_valid[sel] & s_ready[sel];
        // cut a packet that reaches the beat limit without last
        force_end = load && !s_last[sel] &&
                    (beat_cnt == LAST_IDX);
        beat_last = s_last[sel] | force_end;
        if (load && beat_last)
          state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      sel      <= 2'd0;
      beat_cnt <= 8'd0;
      pkt_cnt  <= 16'd0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (state == IDLE && state_nxt == XFER)
        beat_cnt <= 8'd0;
      else if (load)
        beat_cnt <= beat_cnt + 8'd1;
      if (load && beat_last)
        pkt_cnt <= pkt_cnt + 16'd1;
      if (grant_bad || force_end)
        err <= 1'b1;
    end
  end

  assign o_pkt_cnt = pkt_cnt;
  assign o_err     = err;

  arb_out_reg #(
    .DW (DW)
  ) u_out (
    .clk     (clk),
    .aresetn (aresetn),
    .load    (load),
    .d_data  (s_data[sel]),
    .d_last  (beat_last),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .out_rdy (out_rdy)
  );

endmodule

// File: tb/tb_arbiter_pkt_mux.sv
// Bench for arbiter_pkt_mux: directed scenarios plus randomized traffic.
// A packet-level model predicts every output each cycle.
module tb_arbiter_pkt_mux;

  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic             clk = 1'b0;
  logic             aresetn;
  logic [3:0]       s_valid, s_last, s_ready;
  logic [3:0]       o_arb_req, i_arb_grant;
  logic [3:0][DW-1:0] s_data;
  logic             m_valid, m_last, m_ready;
  logic [DW-1:0]    m_data;
  logic [15:0]      o_pkt_cnt;
  logic             o_err;

  always #5 clk = ~clk;

  arbiter_pkt_mux #(.DW(DW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
    .s_ready(s_ready), .o_arb_req(o_arb_req),
    .i_arb_grant(i_arb_grant),
    .m_valid(m_valid), .m_last(m_last), .m_data(m_data),
    .m_ready(m_ready), .o_pkt_cnt(o_pkt_cnt), .o_err(o_err)
  );

  typedef struct { logic [31:0] d; logic l; } beat_t;
  typedef struct { logic [31:0] d; logic l; int cyc; } obs_t;

  beat_t src_q[4][$];
  obs_t  log_q[$];

  int total = 0, bad = 0, cyc = 0;
  int vprob = 100, rprob = 100, force_mr = -1, gmode = 0;
  int rr_ptr = 3, watch_hits = 0;
  logic [3:0] watch_req = 4'b0000;
  bit rnd = 0;
  int out_seq[4], in_seq[4];

  // packet-level model state
  bit          busy, mv, merr;
  int          cur, beats;
  logic [31:0] md;
  logic        ml;
  logic [15:0] pcnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy = 0; mv = 0; merr = 0; cur = 0; beats = 0;
    md = '0; ml = 1'b0; pcnt = '0;
  endtask

  task automatic add_pkt(int p, logic [31:0] base, int n, bit endlast);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + 32'(i);
      b.l = endlast && (i == n - 1);
      src_q[p].push_back(b);
    end
  endtask

  function automatic logic [3:0] rr_pick(logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      int idx = (rr_ptr + k) % 4;
      if (req[idx]) begin
        rr_ptr = idx;
        return 4'b0001 << idx;
      end
    end
    return 4'b0000;
  endfunction

  function automatic bit all_done();
    for (int p = 0; p < 4; p++)
      if (src_q[p].size() != 0) return 0;
    return !busy && !mv;
  endfunction

  task automatic check_cycle();
    logic       ordy;
    logic [3:0] ereq, erdy;
    logic       lst;
    int         p;
    ordy = !mv || m_ready;
    ereq = (!busy && ordy) ? s_valid : 4'b0000;
    erdy = (busy && ordy) ? (4'b0001 << cur) : 4'b0000;
    chk("o_arb_req", 32'(o_arb_req), 32'(ereq));
    chk("s_ready", 32'(s_ready), 32'(erdy));
    chk("m_valid", 32'(m_valid), 32'(mv));
    if (mv) begin
      chk("m_data", m_data, md);
      chk("m_last", 32'(m_last), 32'(ml));
    end
    chk("o_pkt_cnt", 32'(o_pkt_cnt), 32'(pcnt));
    chk("o_err", 32'(o_err), 32'(merr));
    if (m_valid && m_ready) begin
      log_q.push_back('{m_data, m_last, cyc});
      if (rnd && m_data[31:28] == 4'hC) begin
        p = int'(m_data[25:24]);
        chk("seq", 32'(m_data[23:0]), 32'(out_seq[p]));
        out_seq[p]++;
      end
    end
    if (!busy) begin
      if (i_arb_grant != 4'b0000) begin
        if ($countones(i_arb_grant) == 1 && (i_arb_grant & ereq) != 0) begin
          busy = 1; beats = 0;
          for (int k = 0; k < 4; k++)
            if (i_arb_grant[k]) cur = k;
        end else begin
          merr = 1;
        end
      end
      if (m_ready) mv = 0;
    end else if (s_valid[cur] && ordy) begin
      beats++;
      lst = s_last[cur] || (beats == MAXB);
      if (beats == MAXB && !s_last[cur]) merr = 1;
      mv = 1; md = s_data[cur]; ml = lst;
      void'(src_q[cur].pop_front());
      if (lst) begin
        busy = 0;
        pcnt++;
      end
    end else if (m_ready) begin
      mv = 0;
    end
  endtask

  task automatic step();
    int r;
    @(negedge clk);
    cyc++;
    for (int p = 0; p < 4; p++) begin
      if (src_q[p].size() != 0 && $urandom_range(99) < vprob) begin
        s_valid[p] = 1'b1;
        s_data[p]  = src_q[p][0].d;
        s_last[p]  = src_q[p][0].l;
      end else begin
        s_valid[p] = 1'b0;
        s_data[p]  = $urandom;
        s_last[p]  = 1'($urandom_range(1));
      end
    end
    if (force_mr >= 0) m_ready = force_mr[0];
    else m_ready = ($urandom_range(99) < rprob);
    #1;
    i_arb_grant = 4'b0000;
    if (o_arb_req != 4'b0000) begin
      case (gmode)
        0: i_arb_grant = rr_pick(o_arb_req);
        1: i_arb_grant = 4'b0000;
        2: i_arb_grant = 4'b0011;
        default: begin
          r = $urandom_range(99);
          if (r < 85) i_arb_grant = rr_pick(o_arb_req);
          else if (r < 95) i_arb_grant = 4'b0000;
          else i_arb_grant = 4'($urandom_range(15));
        end
      endcase
    end
    #1;
    if (o_arb_req == watch_req) watch_hits++;
    check_cycle();
  endtask

  task automatic wait_done(int budget, string nm);
    for (int k = 0; k < budget && !all_done(); k++) step();
    total++;
    if (!all_done()) begin
      bad++;
      $display("FAIL %s: timeout after %0d cycles, got busy expected idle", nm, budget);
    end
  endtask

  task automatic wait_log(int n, int budget, string nm);
    for (int k = 0; k < budget && log_q.size() < n; k++) step();
    chk(nm, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    aresetn = 1'b0;
    i_arb_grant = 4'b0000;
    #1;
    chk({nm, "_mv"}, 32'(m_valid), 32'd0);
    chk({nm, "_ml"}, 32'(m_last), 32'd0);
    chk({nm, "_md"}, m_data, 32'd0);
    chk({nm, "_cnt"}, 32'(o_pkt_cnt), 32'd0);
    chk({nm, "_err"}, 32'(o_err), 32'd0);
    chk({nm, "_rdy"}, 32'(s_ready), 32'd0);
    chk({nm, "_req"}, 32'(o_arb_req), 32'd0);
    s_valid = 4'b0000;
    for (int p = 0; p < 4; p++) src_q[p].delete();
    log_q.delete();
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    s_valid = 4'hF; s_last = 4'h0; s_data = '0;
    m_ready = 1'b0; i_arb_grant = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mv", 32'(m_valid), 32'd0);
    chk("rst_md", m_data, 32'd0);
    chk("rst_cnt", 32'(o_pkt_cnt), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_req", 32'(o_arb_req), 32'd0);
    chk("rst_rdy", 32'(s_ready), 32'd0);
    @(negedge clk);
    s_valid = 4'h0;
    aresetn = 1'b1;

    // single 3-beat packet on port 1
    add_pkt(1, 32'hA1, 3, 1);
    watch_req = 4'b0010; watch_hits = 0;
    wait_done(50, "t1_done");
    watch_req = 4'b1111;
    chk("t1_len", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t1_d0", log_q[0].d, 32'hA1);
      chk("t1_d2", log_q[2].d, 32'hA3);
      chk("t1_l1", 32'(log_q[1].l), 32'd0);
      chk("t1_l2", 32'(log_q[2].l), 32'd1);
      chk("t1_b2b", 32'(log_q[2].cyc - log_q[0].cyc), 32'd2);
    end
    chk("t1_reqcyc", 32'(watch_hits), 32'd1);
    chk("t1_cnt", 32'(o_pkt_cnt), 32'd1);
    log_q.delete();

    // ports 0 and 2 contend; one idle cycle between packets
    rr_ptr = 3;
    add_pkt(0, 32'hB0, 2, 1);
    add_pkt(2, 32'hC0, 2, 1);
    wait_done(50, "t2_done");
    chk("t2_len", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      chk("t2_d1", log_q[1].d, 32'hB1);
      chk("t2_d2", log_q[2].d, 32'hC0);
      chk("t2_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd2);
    end
    log_q.delete();

    // sink stall for 5 cycles mid-packet
    add_pkt(1, 32'hD0, 4, 1);
    force_mr = 1;
    wait_log(1, 50, "t3_first");
    force_mr = 0;
    repeat (5) step();
    chk("t3_hold", m_data, 32'hD1);
    chk("t3_srdy", 32'(s_ready), 32'd0);
    force_mr = 1;
    wait_done(50, "t3_done");
    chk("t3_len", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4)
      chk("t3_d3", log_q[3].d, 32'hD3);
    force_mr = -1;
    log_q.delete();

    // multi-hot grant then withheld grant
    add_pkt(0, 32'hE0, 1, 1);
    gmode = 2;
    step();
    gmode = 1;
    repeat (3) step();
    chk("t4_err", 32'(o_err), 32'd1);
    chk("t4_nolog", 32'(log_q.size()), 32'd0);
    chk("t4_req", 32'(o_arb_req), 32'b0001);
    gmode = 0;
    wait_done(50, "t4_done");
    chk("t4_errkeep", 32'(o_err), 32'd1);
    chk("t4_len", 32'(log_q.size()), 32'd1);
    log_q.delete();

    // reset in the middle of a packet
    add_pkt(2, 32'hF0, 4, 1);
    wait_log(1, 50, "t5_first");
    do_reset("t5");
    add_pkt(3, 32'h11, 2, 1);
    wait_done(50, "t5_done");
    chk("t5_len", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("t5_d0", log_q[0].d, 32'h11);
      chk("t5_l1", 32'(log_q[1].l), 32'd1);
    end
    chk("t5_cnt", 32'(o_pkt_cnt), 32'd1);
    chk("t5_err", 32'(o_err), 32'd0);
    log_q.delete();

    // 6 beats without last against a 4-beat limit
    add_pkt(1, 32'h60, 6, 1);
    wait_done(60, "t6_done");
    chk("t6_len", 32'(log_q.size()), 32'd6);
    if (log_q.size() == 6) begin
      chk("t6_l2", 32'(log_q[2].l), 32'd0);
      chk("t6_l3", 32'(log_q[3].l), 32'd1);
      chk("t6_d4", log_q[4].d, 32'h64);
      chk("t6_l5", 32'(log_q[5].l), 32'd1);
    end
    chk("t6_cnt", 32'(o_pkt_cnt), 32'd3);
    chk("t6_err", 32'(o_err), 32'd1);

    // randomized traffic
    do_reset("t7");
    rnd = 1;
    for (int p = 0; p < 4; p++) begin
      out_seq[p] = 0;
      in_seq[p]  = 0;
      for (int k = 0; k < 8; k++) begin
        int n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
          beat_t b;
          b.d = {4'hC, 2'b00, 2'(p), 24'(in_seq[p])};
          b.l = (i == n - 1);
          src_q[p].push_back(b);
          in_seq[p]++;
        end
      end
    end
    vprob = 70; rprob = 70; gmode = 3;
    wait_done(4000, "t7_done");
    for (int p = 0; p < 4; p++)
      chk("t7_count", 32'(out_seq[p]), 32'(in_seq[p]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbiter_pkt_mux.md
ARBITER_PKT_MUX -- requirements
Module: arbiter_pkt_mux

Interface
REQ-001 SHALL have parameter DW, default 32, data width per beat.
REQ-002 SHALL have parameter MAX_BEATS, default 64, maximum beats per packet before forced termination (range 2..256).
REQ-003 SHALL have port clk  input  1  clock; single clock domain, all logic on its rising edge.
REQ-004 SHALL have port aresetn  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have ports s_valid / s_last  input  4  per-requester packet stream valid / end-of-packet.
REQ-006 SHALL have port s_data  input  4xDW  per-requester beat data.
REQ-007 SHALL have port s_ready  output  4  per-requester beat accept.
REQ-008 SHALL have port o_arb_req  output  4  requests driven to the downstream round-robin arbiter.
REQ-009 SHALL have port i_arb_grant  input  4  one-hot combinational grant returned by that arbiter.
REQ-010 SHALL have ports m_valid / m_last  output  1  and m_data  output  DW  merged output stream.
REQ-011 SHALL have port m_ready  input  1  output back-pressure.
REQ-012 SHALL have ports o_pkt_cnt  output  16  packets completed (wraps); o_err  output  1  sticky error.

Function
REQ-013 SHALL implement FSM with states IDLE and XFER.
REQ-014 In IDLE, o_arb_req SHALL equal s_valid when the output register can accept (out_rdy = !m_valid | m_ready), else 4'b0000; in XFER, o_arb_req SHALL be 4'b0000.
REQ-015 In IDLE, a one-hot i_arb_grant with o_arb_req[g]=1 SHALL latch sel=g and move to XFER next cycle; no beat transfers in the grant cycle.
REQ-016 In IDLE, i_arb_grant=0 (arbiter withholding for credit) SHALL keep IDLE without error.
REQ-017 i_arb_grant multi-hot, or granting a port whose o_arb_req bit is 0, SHALL be ignored (stay IDLE) and set o_err.
REQ-018 In XFER, s_ready[sel]=out_rdy and all other s_ready bits SHALL be 0; s_ready SHALL be 4'b0000 in IDLE.
REQ-019 An accepted beat (s_valid[sel] & s_ready[sel]) SHALL load m_data/m_last/m_valid=1 on the next edge (latency 1 cycle).
REQ-020 Output register SHALL clear m_valid when m_ready=1 and no new beat is loaded; m_data/m_last SHALL hold while m_valid=1 and m_ready=0.
REQ-021 Accepted beat with s_last=1 SHALL return FSM to IDLE and increment o_pkt_cnt (0xFFFF wraps to 0x0000).
REQ-022 A beat counter (8-bit) SHALL clear on entering XFER and increment per accepted beat.
REQ-023 When the accepted beat is number MAX_BEATS and s_last=0, the block SHALL drive m_last=1 for that beat, return to IDLE, increment o_pkt_cnt, and set o_err.
REQ-024 Throughput: back-to-back packets SHALL incur exactly one IDLE (arbitration) cycle between the last beat of one and the first beat of the next.
REQ-025 s_valid deasserting mid-packet SHALL stall XFER without leaving it; sel SHALL not change until packet end.
REQ-026 o_err SHALL remain 1 until reset.

Reset
REQ-027 On aresetn=0 the block SHALL immediately enter IDLE with sel=0, beat counter=0, m_valid=0, m_last=0, m_data=0, o_pkt_cnt=0, o_err=0.
REQ-028 Reset mid-packet SHALL discard the in-flight beat and partial packet; no resume after release.
REQ-029 Combinational outputs (s_ready, o_arb_req) SHALL be 0 while aresetn=0.

Structure
REQ-030 Shared package arb_pkg SHALL hold N_REQ=4, the FSM state enum, and the default DW.
REQ-031 Output register (valid/data/last, out_rdy) SHALL be a sub-module arb_out_reg; FSM, select mux and counters stay in the top.
REQ-032 The arbiter SHALL NOT be instantiated inside; it connects externally via o_arb_req/i_arb_grant.

Verification
REQ-033 Port1 sends 3-beat packet (0xA1,0xA2,0xA3), grant=4'b0010, m_ready=1 -> o_arb_req=0010 one cycle, m_data A1..A3 consecutive, m_last on A3, o_pkt_cnt=1.
REQ-034 Ports 0 and 2 valid, grant 0001 then 0100 -> packet 0 fully out, one idle cycle, then packet 2; s_ready[2]=0 throughout packet 0.
REQ-035 m_ready=0 for 5 cycles mid-packet -> m_data held stable, s_ready[sel]=0, no beat lost or duplicated.
REQ-036 grant=4'b0011 in IDLE -> no transfer, o_err=1 and stays 1; grant=0 with requests -> IDLE, o_err unchanged.
REQ-037 MAX_BEATS=4, packet of 6 beats without last -> beat 4 emitted with m_last=1, o_err=1, FSM IDLE, remaining beats re-arbitrated as new packet.
REQ-038 aresetn pulsed low during beat 2 of a packet -> all outputs zero same cycle, o_pkt_cnt=0, next packet after release starts cleanly.
